// File: rtl/fetch.sv
// Instruction fetch stage: word reads over a req/ack port, a 4-entry Thumb halfword
// queue, and one instruction per cycle to decode under stall/normal/branch control.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [15:0] NOP_IR   = 16'hBF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  i_mode,
  input  logic [31:0] i_branch_target,
  output logic        o_imem_req_r,
  output logic [31:0] o_imem_addr_r,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [15:0] o_ir_r,
  output logic        o_ir_valid_r,
  output logic [31:0] o_pc_r
);

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] HALF_MASK = 32'hFFFF_FFFE;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        skip_low_q, skip_low_d;

  logic [15:0] queue_q [4];
  logic [15:0] queue_d [4];
  logic [1:0]  head_q, head_d;
  logic [2:0]  count_q, count_d;
  logic [31:0] pop_pc_q, pop_pc_d;

  logic [15:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic [31:0] pc_q, pc_d;

  logic        mode_branch;
  logic        mode_pop;
  logic        pop;
  logic        ack_any;
  logic        ack_data;
  logic        want_req;
  logic [2:0]  push_n;
  logic [2:0]  count_net;
  logic [1:0]  wr_idx0;
  logic [1:0]  wr_idx1;
  logic [31:0] target;

  // Mode 3 decodes as normal, so bit 0 alone selects a pop.
  always_comb begin
    mode_branch = (i_mode == 2'd2);
    mode_pop    = i_mode[0];
    pop         = mode_pop && (count_q != 3'd0);
    ack_any     = req_q && i_imem_ack;
    ack_data    = (state_q == REQ) && ack_any && !mode_branch;
    push_n      = ack_data ? (skip_low_q ? 3'd1 : 3'd2) : 3'd0;
    count_net   = count_q - {2'b00, pop} + push_n;
    want_req    = (count_net <= 3'd2) && !mode_branch;
    target      = i_branch_target & HALF_MASK;
  end

  // Writes index from the pre-pop head: a request only issues with two free
  // slots, so the incoming halfwords never land on a still-occupied entry.
  always_comb begin
    queue_d = queue_q;
    wr_idx0 = head_q + count_q[1:0];
    wr_idx1 = wr_idx0 + 2'd1;
    if (ack_data) begin
      if (skip_low_q) begin
        queue_d[wr_idx0] = i_imem_rdata[31:16];
      end else begin
        queue_d[wr_idx0] = i_imem_rdata[15:0];
        queue_d[wr_idx1] = i_imem_rdata[31:16];
      end
    end
    head_d  = head_q + {1'b0, pop};
    count_d = mode_branch ? 3'd0 : count_net;
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    skip_low_d = skip_low_q;
    unique case (state_q)
      IDLE: begin
        if (want_req) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q & WORD_MASK;
        end
      end
      REQ: begin
        if (mode_branch) begin
          if (ack_any) begin
            state_d = IDLE;
            req_d   = 1'b0;
          end else begin
            state_d = DROP;
          end
        end else if (ack_any) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          skip_low_d = 1'b0;
          if (want_req) begin
            addr_d = fetch_pc_d & WORD_MASK;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
          end
        end
      end
      DROP: begin
        if (ack_any) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
    if (mode_branch) begin
      fetch_pc_d = target;
      skip_low_d = i_branch_target[1];
    end
  end

  always_comb begin
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    pc_d       = pc_q;
    pop_pc_d   = pop_pc_q;
    if (mode_branch) begin
      ir_d       = NOP_IR;
      ir_valid_d = 1'b0;
      pop_pc_d   = target;
    end else if (mode_pop) begin
      if (count_q != 3'd0) begin
        ir_d       = queue_q[head_q];
        ir_valid_d = 1'b1;
        pc_d       = pop_pc_q;
        pop_pc_d   = pop_pc_q + 32'd2;
      end else begin
        ir_d       = NOP_IR;
        ir_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC & WORD_MASK;
      fetch_pc_q <= RESET_PC & HALF_MASK;
      skip_low_q <= RESET_PC[1];
      for (int unsigned i = 0; i < 4; i++) begin
        queue_q[i] <= '0;
      end
      head_q     <= '0;
      count_q    <= '0;
      pop_pc_q   <= RESET_PC & HALF_MASK;
      ir_q       <= NOP_IR;
      ir_valid_q <= 1'b0;
      pc_q       <= RESET_PC;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      skip_low_q <= skip_low_d;
      queue_q    <= queue_d;
      head_q     <= head_d;
      count_q    <= count_d;
      pop_pc_q   <= pop_pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      pc_q       <= pc_d;
    end
  end

  assign o_imem_req_r  = req_q;
  assign o_imem_addr_r = addr_q;
  assign o_ir_r        = ir_q;
  assign o_ir_valid_r  = ir_valid_q;
  assign o_pc_r        = pc_q;

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: behavioural memory with configurable wait states, an instruction
// scoreboard model checked every cycle, directed scenarios and randomized modes.
module tb_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [15:0] NOP    = 16'hBF00;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  i_mode = 2'd1;
  logic [31:0] i_branch_target = '0;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        o_imem_req_r;
  logic [31:0] o_imem_addr_r;
  logic [15:0] o_ir_r;
  logic        o_ir_valid_r;
  logic [31:0] o_pc_r;

  fetch #(.RESET_PC(RST_PC), .NOP_IR(NOP)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_mode          (i_mode),
    .i_branch_target (i_branch_target),
    .o_imem_req_r    (o_imem_req_r),
    .o_imem_addr_r   (o_imem_addr_r),
    .i_imem_ack      (i_imem_ack),
    .i_imem_rdata    (i_imem_rdata),
    .o_ir_r          (o_ir_r),
    .o_ir_valid_r    (o_ir_valid_r),
    .o_pc_r          (o_pc_r)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1C4A_2005;
  endfunction

  function automatic logic [15:0] hw(input logic [31:0] pc);
    logic [31:0] w;
    w = mem_word({pc[31:2], 2'b00});
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Memory: acks wait_states cycles after a request starts; may ack spuriously when idle.
  int unsigned wait_states = 0;
  bit          spurious    = 1'b0;
  bit          force_ack   = 1'b0;
  int unsigned wcnt        = 0;
  bit          acked       = 1'b0;

  always begin
    @(posedge clk);
    #1;
    if (rst || !o_imem_req_r) begin
      wcnt         = 0;
      acked        = 1'b0;
      i_imem_ack   = force_ack || (spurious && ($urandom_range(0, 3) == 0));
      i_imem_rdata = $urandom();
    end else begin
      if (acked) wcnt = 0;
      if (wcnt >= wait_states) begin
        i_imem_ack   = 1'b1;
        i_imem_rdata = mem_word(o_imem_addr_r);
        acked        = 1'b1;
      end else begin
        i_imem_ack   = 1'b0;
        i_imem_rdata = $urandom();
        acked        = 1'b0;
        wcnt++;
      end
    end
  end

  // Reference model: queue of (pc, instruction) pairs plus request bookkeeping.
  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] ir;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_fetch = RST_PC & 32'hFFFF_FFFE;
  logic [31:0] m_addr  = RST_PC & 32'hFFFF_FFFC;
  logic [31:0] m_pc    = RST_PC;
  logic        m_req   = 1'b0;
  logic        m_drop  = 1'b0;
  logic        m_valid = 1'b0;
  logic [15:0] m_ir    = NOP;
  ent_t        e;
  logic        acc, br;
  logic [31:0] base;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_fetch = RST_PC & 32'hFFFF_FFFE;
      m_addr  = RST_PC & 32'hFFFF_FFFC;
      m_pc    = RST_PC;
      m_req   = 1'b0;
      m_drop  = 1'b0;
      m_valid = 1'b0;
      m_ir    = NOP;
    end else begin
      acc = m_req && i_imem_ack;
      br  = (i_mode == 2'd2);
      if (br) begin
        m_ir    = NOP;
        m_valid = 1'b0;
      end else if (i_mode[0]) begin
        if (m_q.size() > 0) begin
          e       = m_q.pop_front();
          m_ir    = e.ir;
          m_pc    = e.pc;
          m_valid = 1'b1;
        end else begin
          m_ir    = NOP;
          m_valid = 1'b0;
        end
      end
      if (br) begin
        m_q.delete();
        m_fetch = i_branch_target & 32'hFFFF_FFFE;
        if (m_req && !acc) begin
          m_drop = 1'b1;
        end else begin
          m_req  = 1'b0;
          m_drop = 1'b0;
        end
      end else if (m_req) begin
        if (acc) begin
          if (m_drop) begin
            m_drop = 1'b0;
            m_req  = 1'b0;
          end else begin
            base = m_addr;
            if (!m_fetch[1]) m_q.push_back('{pc: base, ir: i_imem_rdata[15:0]});
            m_q.push_back('{pc: base + 32'd2, ir: i_imem_rdata[31:16]});
            m_fetch = base + 32'd4;
            if (m_q.size() <= 2) m_addr = m_fetch;
            else m_req = 1'b0;
          end
        end
      end else if (m_q.size() <= 2) begin
        m_req  = 1'b1;
        m_addr = {m_fetch[31:2], 2'b00};
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("imem_req", o_imem_req_r, m_req);
      chk("imem_addr", o_imem_addr_r, m_addr);
      chk("ir_valid", o_ir_valid_r, m_valid);
      chk("ir", o_ir_r, m_ir);
      chk("pc", o_pc_r, m_pc);
      if (o_ir_valid_r) chk("ir_vs_mem", o_ir_r, hw(o_pc_r));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] w;
    logic [31:0] sv_pc;
    logic [15:0] sv_ir;
    int          bub;
    int          val;
    int          k;
    int          r;

    i_mode = 2'd1;
    repeat (3) tick();
    chk("rst_req", o_imem_req_r, 0);
    chk("rst_addr", o_imem_addr_r, 32'h0);
    chk("rst_ir", o_ir_r, 16'hBF00);
    chk("rst_valid", o_ir_valid_r, 0);
    chk("rst_pc", o_pc_r, 32'h0);

    rst = 1'b0;
    tick();
    chk("e1_req", o_imem_req_r, 1);
    chk("e1_addr", o_imem_addr_r, 32'h0);
    tick();
    tick();
    chk("e3_ir", o_ir_r, 16'h2005);
    chk("e3_valid", o_ir_valid_r, 1);
    chk("e3_pc", o_pc_r, 32'h0);
    tick();
    chk("e4_ir", o_ir_r, 16'h1C4A);
    chk("e4_pc", o_pc_r, 32'h2);
    for (int i = 2; i < 16; i++) begin
      tick();
      chk("stream_valid", o_ir_valid_r, 1);
      chk("stream_pc", o_pc_r, 32'(2 * i));
    end

    sv_ir  = o_ir_r;
    sv_pc  = o_pc_r;
    i_mode = 2'd0;
    repeat (3) begin
      tick();
      chk("stall_ir", o_ir_r, sv_ir);
      chk("stall_pc", o_pc_r, sv_pc);
    end
    chk("stall_req_off", o_imem_req_r, 0);
    i_mode = 2'd1;
    tick();
    chk("resume_valid", o_ir_valid_r, 1);
    chk("resume_pc", o_pc_r, sv_pc + 32'd2);

    wait_states = 3;
    bub = 0;
    val = 0;
    repeat (60) begin
      tick();
      if (o_ir_valid_r) val++;
      else bub++;
    end
    chk("ws3_bubbles_seen", bub != 0, 1);
    chk("ws3_valid_seen", val != 0, 1);

    wait_states     = 2;
    i_mode          = 2'd2;
    i_branch_target = 32'h0;
    tick();
    i_mode = 2'd1;
    k = 0;
    while (!(o_imem_req_r && o_imem_addr_r == 32'h10 && !i_imem_ack) && k < 200) begin
      tick();
      k++;
    end
    chk("wait_req_0x10", k < 200, 1);
    i_mode          = 2'd2;
    i_branch_target = 32'h102;
    tick();
    i_mode = 2'd1;
    k = 0;
    while (o_imem_req_r && k < 50) begin tick(); k++; end
    chk("drop_done", k < 50, 1);
    k = 0;
    while (!o_imem_req_r && k < 50) begin tick(); k++; end
    chk("br_new_req", k < 50, 1);
    chk("br_addr", o_imem_addr_r, 32'h100);
    k = 0;
    while (!o_ir_valid_r && k < 50) begin tick(); k++; end
    chk("br_first_valid", k < 50, 1);
    w = mem_word(32'h100);
    chk("br_first_ir", o_ir_r, {16'h0000, w[31:16]});
    chk("br_first_pc", o_pc_r, 32'h102);

    wait_states     = 0;
    i_mode          = 2'd2;
    i_branch_target = 32'hFFFF_FFFC;
    tick();
    i_mode = 2'd1;
    k = 0;
    while (!o_ir_valid_r && k < 50) begin tick(); k++; end
    chk("wrap_valid", k < 50, 1);
    chk("wrap_pc0", o_pc_r, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc1", o_pc_r, 32'hFFFF_FFFE);
    tick();
    chk("wrap_pc2", o_pc_r, 32'h0);
    chk("wrap_valid2", o_ir_valid_r, 1);
    tick();
    chk("wrap_pc3", o_pc_r, 32'h2);

    spurious = 1'b1;
    val = 0;
    for (int c = 0; c < 2000; c++) begin
      if (c % 64 == 0) wait_states = $urandom_range(0, 3);
      r = $urandom_range(0, 99);
      if (r < 55) i_mode = 2'd1;
      else if (r < 70) i_mode = 2'd3;
      else if (r < 93) i_mode = 2'd0;
      else begin
        i_mode          = 2'd2;
        i_branch_target = $urandom();
      end
      tick();
      if (o_ir_valid_r) val++;
    end
    chk("rand_progress", val > 100, 1);

    spurious    = 1'b0;
    wait_states = 3;
    i_mode      = 2'd1;
    k = 0;
    while (!(o_imem_req_r && !i_imem_ack) && k < 50) begin tick(); k++; end
    chk("rst_wait_req", k < 50, 1);
    #1;
    rst       = 1'b1;
    force_ack = 1'b1;
    #1;
    chk("rst_async_req", o_imem_req_r, 0);
    chk("rst_async_addr", o_imem_addr_r, RST_PC);
    chk("rst_async_valid", o_ir_valid_r, 0);
    tick();
    tick();
    wait_states = 0;
    rst = 1'b0;
    tick();
    force_ack = 1'b0;
    chk("rel_req", o_imem_req_r, 1);
    chk("rel_addr", o_imem_addr_r, RST_PC);
    k = 0;
    while (!o_ir_valid_r && k < 50) begin tick(); k++; end
    chk("rel_valid", k < 50, 1);
    chk("rel_ir", o_ir_r, 16'h2005);
    chk("rel_pc", o_pc_r, 32'h0);

    repeat (10) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction fetch stage directly upstream of the decoder.
- Keeps the fetch PC and issues 32-bit word reads to instruction memory over a req/ack handshake.
- Buffers fetched words as 16-bit Thumb halfwords in a 4-entry queue and presents one instruction per cycle on o_ir, which drives decode i_ir.
- Obeys the decoder's mode control: 0 stall, 1 normal, 2 branch.

Parameters:
RESET_PC, 32'h0000_0000, byte address of the first instruction after reset (bit 0 ignored)
NOP_IR, 16'hBF00, bubble instruction driven on o_ir when no valid instruction is available

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
i_mode  in  2  from decode o_mode_r: 0 stall, 1 normal, 2 branch; 3 treated as 1
i_branch_target  in  32  branch byte address, sampled when i_mode==2; bit 0 ignored
o_imem_req_r  out  1  memory read request
o_imem_addr_r  out  32  word address of request, bits [1:0]==0
i_imem_ack  in  1  memory acknowledge; i_imem_rdata valid in the same cycle
i_imem_rdata  in  32  read data, little-endian (bits [15:0] = lower halfword address)
o_ir_r  out  16  instruction to decode
o_ir_valid_r  out  1  o_ir_r holds a real instruction (0 = bubble)
o_pc_r  out  32  byte address of the instruction in o_ir_r

Behaviour:
- Reset values (async):
  - o_ir_r = NOP_IR, o_ir_valid_r = 0, o_pc_r = RESET_PC.
  - o_imem_req_r = 0, o_imem_addr_r = RESET_PC & ~3.
  - Queue empty (count 0); fetch PC = RESET_PC & ~1; FSM = IDLE; skip_low = RESET_PC[1].
- Queue:
  - 4 halfword entries, count 0..4.
  - Push of 1 or 2 halfwords and pop of 1 may occur in the same cycle; count updates by net amount.
  - Overflow is impossible by construction (see request rule).
- FSM states: IDLE, REQ, DROP.
  - IDLE -> REQ when (count after this cycle's pop) + 2 <= 4 and i_mode != 2. Drives req=1 and addr = fetch PC & ~3 on the next edge.
  - REQ: req and addr held stable until i_imem_ack=1.
    - On ack: push rdata halfwords (low first). If skip_low=1, push only rdata[31:16] and clear skip_low.
    - Then fetch PC += 4, mod 2^32.
    - If the request condition still holds, stay in REQ with the new addr (back-to-back); else go to IDLE with req=0.
  - DROP: entered when a branch arrives while in REQ without ack in that cycle. req held until ack; data discarded; then go to IDLE.
  - At most one outstanding request. Ack while req==0 is ignored.
- Pop (i_mode==1 or 3):
  - If the queue is non-empty: o_ir_r <= head, o_ir_valid_r <= 1, o_pc_r <= pop PC, pop PC += 2.
  - If empty: o_ir_r <= NOP_IR, o_ir_valid_r <= 0; o_pc_r holds.
- Stall (i_mode==0): o_ir_r, o_ir_valid_r, o_pc_r hold. Fetching continues while there is room in the queue.
- Branch (i_mode==2), effective at the same edge:
  - Queue flushed (count 0).
  - fetch PC = target & ~1; pop PC = target & ~1; skip_low = target[1].
  - o_ir_r = NOP_IR, o_ir_valid_r = 0.
  - Ack in the branch cycle: data discarded, FSM -> IDLE.
  - REQ without ack: FSM -> DROP.
  - New request issues on the edge after the branch (IDLE) or after the DROP ack.
- Latency, zero-wait memory (ack in the first req cycle):
  - First req on edge 1 after reset release.
  - Data pushed on edge 2; first valid o_ir_r on edge 3.
  - Steady-state throughput: 1 instruction/cycle.
- Reset mid-transaction: req drops immediately; no data from the aborted request enters the queue.
- PC arithmetic is 32-bit wrap-around; fetch from 0xFFFF_FFFC is followed by 0x0000_0000.

Test Plan:
- Reset release, RESET_PC=0, zero-wait memory, word0=0x1C4A_2005:
  - req=1 addr=0 at edge 1.
  - o_ir_r=0x2005 valid, pc=0 at edge 3.
  - o_ir_r=0x1C4A, pc=2 at edge 4.
- Continuous zero-wait streaming over 8 words: 16 consecutive valid instructions, pc 0..0x1E step 2, no bubbles, count never exceeds 4.
- i_mode=0 for 3 cycles mid-stream: o_ir_r/o_pc_r constant, req deasserts once count reaches 4; on resume the sequence continues with no loss or duplication.
- Branch to 0x102 while a request to 0x10 is waiting (ack 2 cycles later):
  - Ack data is discarded.
  - Next req addr=0x100; first valid o_ir_r = word[0x100][31:16], pc=0x102.
- 3-wait-state memory (ack 3 cycles after req rises): o_ir_valid_r shows bubbles with o_ir_r=0xBF00 between bursts; every instruction delivered in order.
- Assert rst while req=1 and ack pending: req=0 immediately; late ack ignored; after release, the first req is addr=RESET_PC.
